// File: rtl/imem_responder.sv
// Instruction-memory responder for the IF stage.
// Accepts one word fetch per cycle and returns the instruction LATENCY cycles
// later, in order, through an output FIFO that absorbs IF stalls. A credit
// counter (in flight + buffered) throttles acceptance so the FIFO never
// overflows. A backdoor port fills program memory; reset never clears it.
module imem_responder #(
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 2,
  parameter int          OUTST    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = $clog2(OUTST);
  localparam int CW   = PW + 1;
  localparam int LAST = LATENCY - 1;
  localparam logic [CW-1:0] LP_OUTST = CW'(OUTST);
  localparam logic [CW-1:0] LP_ONE   = {{(CW-1){1'b0}}, 1'b1};

  // Program memory and the data half of the pipeline/FIFO (no reset needed)
  logic [31:0]        r_mem    [DEPTH];
  logic [31:0]        r_p_inst [LATENCY];
  logic [31:0]        r_f_inst [OUTST];
  logic               r_f_err  [OUTST];

  // Control state (reset)
  logic [LATENCY-1:0] r_p_vld;
  logic [LATENCY-1:0] r_p_err;
  logic [PW:0]        r_wr_ptr;
  logic [PW:0]        r_rd_ptr;
  logic [CW-1:0]      r_credits;
  logic               r_ready_en;

  logic               w_accept;
  logic               w_pop;
  logic               w_req_err;
  logic               w_ld_ok;
  logic               w_empty;
  logic [AW-1:0]      w_req_idx;
  logic [AW-1:0]      w_ld_idx;
  logic [PW-1:0]      w_wr_idx;
  logic [PW-1:0]      w_rd_idx;

  assign w_req_idx = req_addr[2 +: AW];
  assign w_ld_idx  = ld_addr[2 +: AW];
  assign w_wr_idx  = r_wr_ptr[PW-1:0];
  assign w_rd_idx  = r_rd_ptr[PW-1:0];

  // Misaligned or beyond the last word: any address bit above the index is set
  assign w_req_err = (req_addr[1:0] != 2'b00) ||
                     (req_addr[31:AW+2] != {(30-AW){1'b0}});
  assign w_ld_ok   = (ld_addr[1:0] == 2'b00) &&
                     (ld_addr[31:AW+2] == {(30-AW){1'b0}});

  // Ready depends only on credits (and the post-reset enable), never on req_valid
  assign req_ready  = r_ready_en && (r_credits < LP_OUTST);
  assign w_accept   = req_valid && req_ready;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign resp_valid = !w_empty;
  assign w_pop      = resp_valid && resp_ready;
  assign resp_inst  = w_empty ? NOP_WORD : r_f_inst[w_rd_idx];
  assign resp_err   = !w_empty && r_f_err[w_rd_idx];
  assign busy       = (r_credits != {CW{1'b0}});

  // Memory write, read-before-write stage-0 fetch, data shift and FIFO payload write
  always_ff @(posedge clk) begin
    if (ld_en && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
    r_p_inst[0] <= r_mem[w_req_idx];
    for (int i = 1; i < LATENCY; i++) begin
      r_p_inst[i] <= r_p_inst[i-1];
    end
    if (r_p_vld[LAST]) begin
      r_f_inst[w_wr_idx] <= r_p_err[LAST] ? NOP_WORD : r_p_inst[LAST];
      r_f_err[w_wr_idx]  <= r_p_err[LAST];
    end
  end

  // Pipeline valids, FIFO pointers, credit counter and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_p_vld    <= {LATENCY{1'b0}};
      r_p_err    <= {LATENCY{1'b0}};
      r_wr_ptr   <= {(PW+1){1'b0}};
      r_rd_ptr   <= {(PW+1){1'b0}};
      r_credits  <= {CW{1'b0}};
    end else begin
      r_ready_en <= 1'b1;
      r_p_vld[0] <= w_accept;
      r_p_err[0] <= w_req_err;
      for (int i = 1; i < LATENCY; i++) begin
        r_p_vld[i] <= r_p_vld[i-1];
        r_p_err[i] <= r_p_err[i-1];
      end
      // The credit limit guarantees a free FIFO slot whenever the last stage is valid
      if (r_p_vld[LAST]) begin
        r_wr_ptr <= r_wr_ptr + LP_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits + LP_ONE;
        2'b01:   r_credits <= r_credits - LP_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a transaction-level model (memory
// array plus a queue of expected responses with due cycles) is compared with
// the DUT on every falling edge.
module tb_imem_responder;

  localparam int          DEPTH   = 1024;
  localparam int          LATENCY = 2;
  localparam int          OUTST   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic        busy;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .OUTST(OUTST), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_err(resp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [DEPTH];
  int unsigned cyc = 0;
  logic        m_rdy_en;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  logic        rand_rr = 1'b0;
  exp_t        e;
  logic        vis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready becomes 1 at the first clock edge after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rdy_en <= 1'b0;
    else        m_rdy_en <= 1'b1;
  end

  // Reference model: observe handshakes that will occur on the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check_eq("rst_valid", resp_valid, 1'b0);
      check_eq("rst_ready", req_ready, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_inst", resp_inst, NOP);
      check_eq("rst_err", resp_err, 1'b0);
    end else begin
      vis = (q.size() > 0) && (q[0].due <= cyc);
      check_eq("req_ready", req_ready, m_rdy_en && (q.size() < OUTST));
      check_eq("busy", busy, q.size() != 0);
      check_eq("resp_valid", resp_valid, vis);
      if (resp_valid && vis) begin
        check_eq("resp_inst", resp_inst, q[0].inst);
        check_eq("resp_err", resp_err, q[0].err);
        if (resp_ready) void'(q.pop_front());
      end
      if (req_valid && req_ready) begin
        e.err = (req_addr % 4 != 0) || (req_addr >= 32'(4 * DEPTH));
        if (e.err) e.inst = NOP;
        else       e.inst = m_mem[req_addr / 4];
        e.due = cyc + 1 + LATENCY;
        q.push_back(e);
        n_acc++;
      end
      check_eq("credits_le_outst", q.size() <= OUTST, 1'b1);
    end
    // Loads land after the same-edge fetch has read the old word
    if (ld_en && (ld_addr % 4 == 0) && (ld_addr < 32'(4 * DEPTH)))
      m_mem[ld_addr / 4] = ld_data;
  end

  // Random resp_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rr) resp_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic got;
    got = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!got) check_eq("fetch_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0) && !busy;
    end
    tick();
    check_eq("drain", q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          a0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) load(32'(4 * i), $urandom);

    // T1: small program, back-to-back fetches
    load(32'h0, 32'h2008_0001);
    load(32'h4, 32'h2009_0002);
    load(32'h8, 32'h0109_5020);
    load(32'hC, 32'h0000_0000);
    resp_ready = 1'b1;
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    wait_idle();

    // Ignored loads: misaligned and out of range must not alias onto words 1 and 0
    load(32'h5, 32'hBAD0_0001);
    load(32'(4 * DEPTH), 32'hBAD0_0002);
    fetch(32'h0); fetch(32'h4);
    wait_idle();

    // T2: stalled consumer fills exactly OUTST credits
    resp_ready = 1'b0;
    a0 = n_acc;
    req_valid = 1'b1;
    for (int k = 0; k < OUTST + 4; k++) begin
      req_addr = 32'(16 + 4 * k);
      tick();
    end
    check_eq("t2_accepts", n_acc - a0, OUTST);
    check_eq("t2_ready_low", req_ready, 1'b0);
    check_eq("t2_busy", busy, 1'b1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    check_eq("t2_ready_back", req_ready, 1'b1);

    // T3: error fetches keep order and a following aligned fetch is clean
    fetch(32'h2);
    fetch(32'(4 * DEPTH));
    fetch(32'hFFFF_FFFC);
    fetch(32'h14);
    wait_idle();

    // T4: same-edge fetch and load of word 8 returns the old word, refetch the new one
    req_valid = 1'b1; req_addr = 32'h8;
    ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0; ld_en = 1'b0;
    fetch(32'h8);
    wait_idle();

    // T5: reset mid-pipeline discards everything, memory survives
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", resp_valid, 1'b0);
    check_eq("t5_async_busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    wait_idle();

    // T6: 200 sequential PCs with a random consumer
    rand_rr = 1'b1;
    for (int i = 0; i < 200; i++) fetch(32'((64 + 4 * i) % (4 * DEPTH)));

    // Random addresses (some erroneous) with concurrent loads to a small window
    for (int i = 0; i < 120; i++) begin
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 32'(4 * $urandom_range(0, 15));
      ld_data = $urandom;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else                           a = 32'(4 * $urandom_range(0, 15));
      fetch(a);
    end
    ld_en = 1'b0;
    rand_rr = 1'b0;
    #2;
    resp_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
